// File: rtl/insn_loader_pkg.sv
// Shared types and defaults for the instruction loader.
// Holds the loader FSM state encoding and the default memory geometry.
package insn_loader_pkg;

    localparam int DEPTH_DEF  = 1024;
    localparam int ADDR_W_DEF = 10;
    localparam int WORD_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_DONE,
        ST_ERR
    } ld_state_t;

endpackage

// File: rtl/insn_loader.sv
// Instruction loader: zero-fills instruction memory, streams a program in,
// and releases the downstream core from reset once the load completes.
module insn_loader
    import insn_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              core_reset_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);

    ld_state_t         state;
    logic [ADDR_W-1:0] clr_addr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            clr_addr     <= '0;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            core_reset_n <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            word_count   <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    // Core runs only after a full cycle spent in DONE.
                    core_reset_n <= (state == ST_DONE);
                    if (start) begin
                        state        <= ST_CLEAR;
                        clr_addr     <= '0;
                        word_count   <= '0;
                        core_reset_n <= 1'b0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= clr_addr;
                    mem_wdata <= '0;
                    clr_addr  <= clr_addr + 1'b1;
                    if (clr_addr == LAST_ADDR) begin
                        state    <= ST_LOAD;
                        clr_addr <= '0;
                        in_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= word_count[ADDR_W-1:0];
                        mem_wdata  <= in_data;
                        word_count <= word_count + 1'b1;
                        if (in_last) begin
                            state    <= ST_DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else if (word_count == LAST_CNT) begin
                            state    <= ST_ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    in_ready     <= 1'b0;
                    core_reset_n <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    err          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_insn_loader.sv
// Self-checking bench for insn_loader with a small behavioural model.
// The bench also plays the role of the instruction memory.
module tb_insn_loader;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_last;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_reset_n;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;

    insn_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .core_reset_n(core_reset_n),
        .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory seen through the DUT write port, and the model's memory.
    logic [31:0] dmem [DEPTH];
    logic [31:0] emem [DEPTH];
    always @(posedge clk) if (mem_we) dmem[mem_addr] <= mem_wdata;

    // Behavioural model: what the loader must look like after each edge.
    typedef enum {M_IDLE, M_CLEAR, M_LOAD, M_DONE, M_ERR} mphase_t;
    mphase_t     ph = M_IDLE;
    mphase_t     ph_prev = M_IDLE;
    int          clr_i = 0;
    int          cnt = 0;
    bit          e_we = 0;
    bit          e_rst = 0;
    bit          e_crn = 0;
    int          e_addr = 0;
    logic [31:0] e_data = 0;

    always @(posedge clk) begin
        e_we  = 0;
        e_rst = 0;
        if (!reset) begin
            ph = M_IDLE; ph_prev = M_IDLE;
            cnt = 0; clr_i = 0; e_crn = 0;
            e_addr = 0; e_data = 0; e_rst = 1;
        end else begin
            ph_prev = ph;
            case (ph)
                M_CLEAR: begin
                    e_we = 1; e_addr = clr_i; e_data = 0;
                    emem[clr_i] = 0;
                    clr_i++;
                    if (clr_i == DEPTH) ph = M_LOAD;
                end
                M_LOAD: if (in_valid) begin
                    e_we = 1; e_addr = cnt; e_data = in_data;
                    emem[cnt] = in_data;
                    cnt++;
                    if (in_last) ph = M_DONE;
                    else if (cnt == DEPTH) ph = M_ERR;
                end
                default: if (start) begin
                    ph = M_CLEAR; cnt = 0; clr_i = 0;
                end
            endcase
            // Core is released only after one whole cycle already in DONE.
            e_crn = (ph_prev == M_DONE) && (ph == M_DONE);
        end
    end

    bit chk_en = 0;
    always @(negedge clk) if (chk_en) begin
        chk("in_ready", in_ready, ph == M_LOAD);
        chk("busy", busy, ph == M_CLEAR || ph == M_LOAD);
        chk("done", done, ph == M_DONE);
        chk("err", err, ph == M_ERR);
        chk("core_reset_n", core_reset_n, e_crn);
        chk("word_count", word_count, cnt);
        chk("mem_we", mem_we, e_we);
        if (e_we || e_rst) begin
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_data);
        end
    end

    int clr_cycles = 0;
    always @(negedge clk) if (busy && !in_ready) clr_cycles++;

    bit cnt_on = 0;
    int wr_cnt = 0;
    always @(posedge clk) if (cnt_on && mem_we) wr_cnt++;

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Present one word and hold it until it is accepted.
    task automatic push(input logic [31:0] d, input logic l);
        int t = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            bad++; total++;
            $display("FAIL push_timeout: in_ready got 0 want 1");
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("wait_ready", in_ready, 1);
    endtask

    task automatic wait_end();
        int t = 0;
        while (!(done || err) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("wait_end", done || err, 1);
    endtask

    task automatic cmp_mem();
        for (int i = 0; i < DEPTH; i++) chk("mem_model", dmem[i], emem[i]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_crn", core_reset_n, 0);
        chk("rst_flags", {busy, done, err}, 0);
        chk("rst_wc", word_count, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        reset = 1'b1;
        idle(2);

        // Basic three-word program.
        do_start();
        push(32'h03210113, 0);
        push(32'h00108093, 0);
        push(32'h4020B1B3, 1);
        chk("basic_done", done, 1);
        chk("basic_crn_n1", core_reset_n, 0);
        @(negedge clk);
        chk("basic_crn_n2", core_reset_n, 1);
        chk("basic_wc", word_count, 3);
        chk("basic_m0", dmem[0], 32'h03210113);
        chk("basic_m1", dmem[1], 32'h00108093);
        chk("basic_m2", dmem[2], 32'h4020B1B3);

        // Clear wipes stale contents; length of CLEAR is DEPTH cycles.
        for (int i = 0; i < DEPTH; i++) dmem[i] = 32'hFFFFFFFF;
        clr_cycles = 0;
        do_start();
        push(32'h00000013, 1);
        @(negedge clk);
        chk("clr_m0", dmem[0], 32'h13);
        for (int i = 1; i < DEPTH; i++) chk("clr_zero", dmem[i], 0);
        chk("clr_cycles", clr_cycles, DEPTH);

        // Back-pressure: valid pattern 1,0,1,1,0,1.
        do_start();
        wait_ready();
        @(negedge clk);
        wr_cnt = 0; cnt_on = 1;
        push(32'hA1A1A1A1, 0);
        idle(1);
        push(32'hB2B2B2B2, 0);
        push(32'hC3C3C3C3, 0);
        idle(1);
        push(32'hD4D4D4D4, 1);
        @(negedge clk);
        cnt_on = 0;
        chk("bp_writes", wr_cnt, 4);
        chk("bp_m0", dmem[0], 32'hA1A1A1A1);
        chk("bp_m1", dmem[1], 32'hB2B2B2B2);
        chk("bp_m2", dmem[2], 32'hC3C3C3C3);
        chk("bp_m3", dmem[3], 32'hD4D4D4D4);

        // Overflow: DEPTH words without in_last.
        do_start();
        for (int i = 0; i < DEPTH; i++) push(32'h1000 + i, 0);
        chk("ovf_err", err, 1);
        chk("ovf_ready", in_ready, 0);
        chk("ovf_crn", core_reset_n, 0);
        chk("ovf_wc", word_count, DEPTH);
        in_valid = 1'b1; in_data = 32'hDEAD; in_last = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("ovf_m7", dmem[7], 32'h1007);
        chk("ovf_wc_hold", word_count, DEPTH);

        // Reset in the middle of a load.
        do_start();
        push(32'h11, 0);
        push(32'h22, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy, 0);
        chk("mid_crn", core_reset_n, 0);
        chk("mid_wc", word_count, 0);
        chk("mid_we", mem_we, 0);
        reset = 1'b1;
        idle(2);
        chk("mid_we_after", mem_we, 0);

        // Reload from DONE.
        do_start();
        push(32'h55, 1);
        @(negedge clk);
        chk("rl_crn_before", core_reset_n, 1);
        do_start();
        chk("rl_crn", core_reset_n, 0);
        chk("rl_busy", busy, 1);
        chk("rl_wc", word_count, 0);
        push(32'h66, 1);
        @(negedge clk);
        chk("rl_m0", dmem[0], 32'h66);

        // Random programs with random gaps and stray start pulses.
        for (int r = 0; r < 12; r++) begin
            int len;
            len = $urandom_range(1, DEPTH + 1);
            do_start();
            for (int i = 0; i < len && i < DEPTH; i++) begin
                int gap;
                gap = $urandom_range(0, 2);
                if (gap > 0) begin
                    start = ($urandom_range(0, 3) == 0);
                    idle(gap);
                    start = 1'b0;
                end
                push($urandom, (i == len - 1));
            end
            wait_end();
            idle(2);
            cmp_mem();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
